// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: host start/done handshake, instruction memory port, decode side.
// Latency: none (wires only); memory data arrives one cycle after its address.
// Backpressure: none; decode consumes one instruction per valid cycle.
interface fetch_unit_if #(
  parameter int PCW  = 10,
  parameter int IW   = 9,
  parameter int CNTW = 16
);
  logic            Req;
  logic            Ack;
  logic [PCW-1:0]  imem_addr;
  logic [IW-1:0]   imem_data;
  logic [IW-1:0]   instr;
  logic            instr_valid;
  logic [PCW-1:0]  instr_pc;
  logic            BranchTaken;
  logic [PCW-1:0]  br_target;
  logic            Halt;
  logic [CNTW-1:0] cyc_count;
  logic [CNTW-1:0] ret_count;

  // Fetch unit side.
  modport master (
    input  Req, imem_data, BranchTaken, br_target, Halt,
    output Ack, imem_addr, instr, instr_valid, instr_pc, cyc_count, ret_count
  );

  // Host / memory / decode side.
  modport slave (
    output Req, imem_data, BranchTaken, br_target, Halt,
    input  Ack, imem_addr, instr, instr_valid, instr_pc, cyc_count, ret_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives imem address, hands instructions to decode.
// Latency: 1 cycle address-to-valid; a taken branch costs exactly one bubble.
// Backpressure: none; redirect/halt from decode act only on valid instructions.
module fetch_unit #(
  parameter int PCW  = 10,
  parameter int IW   = 9,
  parameter int CNTW = 16
) (
  input logic          Clk,
  input logic          Reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PCW-1:0]  fetch_pc;
  logic [PCW-1:0]  pc_q;
  logic            valid_q;
  logic            ack_q;
  logic [CNTW-1:0] cyc_q;
  logic [CNTW-1:0] ret_q;

  // Memory registers its own data, so the instruction is a straight pass-through.
  assign bus.instr       = bus.imem_data;
  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = pc_q;
  assign bus.imem_addr   = fetch_pc;
  assign bus.Ack         = ack_q;
  assign bus.cyc_count   = cyc_q;
  assign bus.ret_count   = ret_q;

  // Control FSM with PC, valid, done flag and counters as registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      fetch_pc <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      cyc_q    <= '0;
      ret_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          ack_q   <= 1'b0;
          if (bus.Req) begin
            state    <= RUN;
            fetch_pc <= '0;
            cyc_q    <= '0;
            ret_q    <= '0;
          end
        end

        RUN: begin
          if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
          // Default: stream sequentially; the word read now becomes valid next cycle.
          valid_q  <= 1'b1;
          pc_q     <= fetch_pc;
          fetch_pc <= fetch_pc + 1'b1;
          // Redirect and halt only mean something for a live instruction.
          if (valid_q) begin
            if (ret_q != '1) ret_q <= ret_q + 1'b1;
            if (bus.Halt) begin
              state    <= DONE;
              valid_q  <= 1'b0;
              ack_q    <= 1'b1;
              fetch_pc <= fetch_pc;
            end else if (bus.BranchTaken) begin
              // Drop the fall-through word being read this cycle.
              fetch_pc <= bus.br_target;
              valid_q  <= 1'b0;
            end
          end
        end

        DONE: begin
          valid_q <= 1'b0;
          ack_q   <= 1'b1;
          if (bus.Req) begin
            state    <= RUN;
            fetch_pc <= '0;
            cyc_q    <= '0;
            ret_q    <= '0;
            ack_q    <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-trace model builds the expected per-cycle outputs.
// Latency: model assumes one bubble at run start and one per taken branch.
// Backpressure: none; decode controls are driven from the expected trace.
module tb_fetch_unit;
  localparam int PCW   = 4;
  localparam int IW    = 9;
  localparam int CNTW  = 8;
  localparam int DEPTH = 16;
  localparam int CMAX  = 255;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  fetch_unit_if #(.PCW(PCW), .IW(IW), .CNTW(CNTW)) bus ();

  fetch_unit #(.PCW(PCW), .IW(IW), .CNTW(CNTW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Expected outputs for one clock cycle.
  typedef struct {
    bit ack; bit valid; int pc; int addr; int instr; int cyc; int ret;
  } exp_t;

  // One RUN cycle of the architectural trace.
  typedef struct {
    bit valid; int pc; int addr; bit halt; bit br; int tgt;
  } ent_t;

  exp_t exp_q[$];
  ent_t tl[$];
  logic [IW-1:0] mem [DEPTH];
  bit halt_tab [DEPTH];
  bit br_tab   [DEPTH];
  int tgt_tab  [DEPTH];

  int checks = 0;
  int errors = 0;
  int last_ack, last_addr, last_cyc, last_ret;
  int halt_pc;
  int seen4;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Synchronous instruction memory.
  always @(posedge Clk) bus.imem_data <= mem[bus.imem_addr];

  // Compare DUT outputs against the expected record queued for this cycle.
  always @(negedge Clk) begin : cmp
    exp_t e;
    if (bus.instr_valid === 1'b1 && bus.instr_pc == 4'd4) seen4++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("Ack", int'(bus.Ack), int'(e.ack));
      check("instr_valid", int'(bus.instr_valid), int'(e.valid));
      check("imem_addr", int'(bus.imem_addr), e.addr);
      check("cyc_count", int'(bus.cyc_count), e.cyc);
      check("ret_count", int'(bus.ret_count), e.ret);
      if (e.valid) begin
        check("instr_pc", int'(bus.instr_pc), e.pc);
        check("instr", int'(bus.instr), e.instr);
      end
    end
  end

  task automatic noise();
    bus.Halt        = 1'($urandom_range(0, 1));
    bus.BranchTaken = 1'($urandom_range(0, 1));
    bus.br_target   = PCW'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < DEPTH; i++) begin
      halt_tab[i] = 1'b0;
      br_tab[i]   = 1'b0;
      tgt_tab[i]  = 0;
    end
  endtask

  // Walk the program: first cycle is a bubble at address 0, then one valid
  // cycle per executed pc, plus one bubble after every taken branch.
  task automatic build(input int limit);
    ent_t en;
    int pc, nv;
    tl.delete();
    en = '{1'b0, 0, 0, 1'b0, 1'b0, 0};
    tl.push_back(en);
    pc = 0;
    nv = 0;
    while (1) begin
      nv++;
      en = '{1'b1, pc, (pc + 1) % DEPTH, halt_tab[pc] || (nv == limit), br_tab[pc], tgt_tab[pc]};
      tl.push_back(en);
      if (en.halt) begin
        halt_pc = pc;
        break;
      end
      if (en.br) begin
        tl.push_back('{1'b0, 0, en.tgt, 1'b0, 1'b0, 0});
        pc = en.tgt;
      end else begin
        pc = (pc + 1) % DEPTH;
      end
    end
  endtask

  // Start a run with Req, follow the trace, then spend two cycles in DONE.
  // abort_addr >= 0 pulls reset low once the fetch address reaches it.
  task automatic run_prog(input int limit, input int abort_addr);
    exp_t x;
    int nv;
    build(limit);
    @(posedge Clk); #1;
    bus.Req = 1'b1;
    noise();
    x = '{last_ack != 0, 1'b0, 0, last_addr, 0, last_cyc, last_ret};
    exp_q.push_back(x);
    nv = 0;
    for (int k = 0; k < tl.size(); k++) begin
      @(posedge Clk); #1;
      bus.Req = 1'($urandom_range(0, 1));
      if (tl[k].valid) begin
        bus.Halt        = tl[k].halt;
        bus.BranchTaken = tl[k].br;
        bus.br_target   = tl[k].br ? PCW'(tl[k].tgt) : PCW'($urandom_range(0, DEPTH - 1));
      end else begin
        noise();
      end
      x = '{1'b0, tl[k].valid, tl[k].pc, tl[k].addr,
            tl[k].valid ? int'(mem[tl[k].pc]) : 0, sat(k), sat(nv)};
      exp_q.push_back(x);
      if (tl[k].valid) nv++;
      if (abort_addr >= 0 && tl[k].addr == abort_addr) begin
        @(negedge Clk); #1;
        Reset = 1'b0;
        #1;
        check("rst Ack", int'(bus.Ack), 0);
        check("rst instr_valid", int'(bus.instr_valid), 0);
        check("rst instr_pc", int'(bus.instr_pc), 0);
        check("rst imem_addr", int'(bus.imem_addr), 0);
        check("rst cyc_count", int'(bus.cyc_count), 0);
        check("rst ret_count", int'(bus.ret_count), 0);
        bus.Req = 1'b0;
        @(posedge Clk); #2;
        Reset = 1'b1;
        exp_q.delete();
        last_ack = 0; last_addr = 0; last_cyc = 0; last_ret = 0;
        return;
      end
    end
    last_ack  = 1;
    last_addr = (halt_pc + 1) % DEPTH;
    last_cyc  = sat(tl.size());
    last_ret  = sat(nv);
    repeat (2) begin
      @(posedge Clk); #1;
      bus.Req = 1'b0;
      noise();
      x = '{1'b1, 1'b0, 0, last_addr, 0, last_cyc, last_ret};
      exp_q.push_back(x);
    end
    @(negedge Clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Req = 1'b0;
    bus.Halt = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.br_target = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = IW'($urandom_range(0, 511));
    last_ack = 0; last_addr = 0; last_cyc = 0; last_ret = 0;

    // Reset state.
    #12;
    check("reset Ack", int'(bus.Ack), 0);
    check("reset instr_valid", int'(bus.instr_valid), 0);
    check("reset imem_addr", int'(bus.imem_addr), 0);
    check("reset cyc_count", int'(bus.cyc_count), 0);
    check("reset ret_count", int'(bus.ret_count), 0);
    #10;
    Reset = 1'b1;

    // Reset pulled mid-run once fetch_pc reaches 7.
    clear_tabs();
    run_prog(100, 7);

    // Straight line, halt at pc 5.
    clear_tabs();
    halt_tab[5] = 1'b1;
    run_prog(0, -1);
    check("straight Ack", int'(bus.Ack), 1);
    check("straight ret_count", int'(bus.ret_count), 6);
    check("straight cyc_count", int'(bus.cyc_count), 7);

    // Taken branch at pc 3 to 10, halt at 12.
    clear_tabs();
    br_tab[3] = 1'b1; tgt_tab[3] = 10;
    halt_tab[12] = 1'b1;
    seen4 = 0;
    run_prog(0, -1);
    check("branch pc4 never valid", seen4, 0);
    check("branch ret_count", int'(bus.ret_count), 7);
    check("branch cyc_count", int'(bus.cyc_count), 9);

    // Branch and halt together at pc 2: halt wins.
    clear_tabs();
    br_tab[2] = 1'b1; tgt_tab[2] = 9;
    halt_tab[2] = 1'b1;
    run_prog(0, -1);
    check("br+halt ret_count", int'(bus.ret_count), 3);
    check("br+halt imem_addr", int'(bus.imem_addr), 3);

    // Wrap 15->0, halt on the 18th instruction (pc 1), restarted from DONE.
    clear_tabs();
    run_prog(18, -1);
    check("wrap ret_count", int'(bus.ret_count), 18);
    check("wrap cyc_count", int'(bus.cyc_count), 19);
    check("wrap done addr", int'(bus.imem_addr), 2);

    // Long run with a self-loop branch: both counters saturate.
    clear_tabs();
    br_tab[6] = 1'b1; tgt_tab[6] = 6;
    br_tab[9] = 1'b1; tgt_tab[9] = 2;
    run_prog(300, -1);
    check("sat ret_count", int'(bus.ret_count), CMAX);
    check("sat cyc_count", int'(bus.cyc_count), CMAX);

    // Random programs.
    for (int r = 0; r < 12; r++) begin
      clear_tabs();
      for (int i = 0; i < DEPTH; i++) begin
        halt_tab[i] = ($urandom_range(0, 15) == 0);
        br_tab[i]   = ($urandom_range(0, 3) == 0);
        tgt_tab[i]  = $urandom_range(0, DEPTH - 1);
      end
      run_prog($urandom_range(3, 40), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the control decoder.
- Owns the program counter and drives the synchronous instruction-memory address.
- Presents each 9-bit instruction with a valid flag to decode, and accepts branch redirect and halt back from decode/execute.
- Implements the top-level Req/Ack start/done handshake and cycle/instruction counters.

Parameters:
PCW, 10, program counter / instruction memory address width
IW, 9, instruction width
CNTW, 16, width of cycle and retired-instruction counters

Ports:
Clk  input  1  clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
Req  input  1  start request from bench/host
Ack  output  1  program done; high while in DONE
imem_addr  output  PCW  instruction memory read address (memory registers data, 1-cycle latency)
imem_data  input  IW  instruction memory read data for the address presented last cycle
instr  output  IW  instruction to decoder
instr_valid  output  1  instr is live this cycle
instr_pc  output  PCW  address of instr
BranchTaken  input  1  decode/execute resolved taken branch for current instr
br_target  input  PCW  absolute branch target
Halt  input  1  decoder flags current instr as halt
cyc_count  output  CNTW  cycles spent in RUN
ret_count  output  CNTW  instructions retired (valid and not squashed)

Behaviour:
- Reset low (async): state=IDLE; fetch_pc=0, instr_pc=0, valid=0, Ack=0, cyc_count=0, ret_count=0, imem_addr=0. Applies mid-operation, with in-flight fetch discarded.
- instr = imem_data (combinational pass-through); instr_valid = internal valid register; imem_addr = fetch_pc in all states.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - valid=0, Ack=0.
  - Req=1 -> RUN next cycle; fetch_pc=0, valid=0, both counters cleared.
- RUN, every cycle:
  - cyc_count+1, saturating at all-ones.
  - Default: valid<=1, instr_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^PCW, silent wrap).
  - First RUN cycle issues address 0; instr at pc 0 is valid the following cycle, giving 1-cycle fetch latency.
  - valid=1 and Halt=1: instruction retires (ret_count+1); state->DONE; valid<=0; fetch_pc held. Halt has priority over BranchTaken in the same cycle.
  - valid=1, BranchTaken=1, Halt=0: retires (ret_count+1); fetch_pc<=br_target; valid<=0. This squashes the fall-through instruction being read this cycle: exactly one bubble per taken branch. Target instr is valid two cycles after the branch cycle.
  - valid=1, neither asserted: retires (ret_count+1).
  - valid=0: BranchTaken and Halt ignored; no retire.
  - Req ignored in RUN.
- DONE:
  - Ack=1, valid=0; counters frozen; fetch_pc held.
  - Req=1 -> RUN with fetch_pc=0, counters cleared, Ack=0 from next cycle.
- ret_count saturates at all-ones.
- Branch to br_target equal to the branch's own pc is legal and loops with one bubble per iteration.
- No stall input: decode consumes one instruction per valid cycle.

Test Plan:
- Reset low mid-RUN at fetch_pc=7 -> all outputs zero immediately (async), state IDLE; Reset high then Req pulse -> imem_addr 0,1,2,... from first RUN cycle.
- Straight-line program of 5 non-branch words then Halt at pc 5 -> instr_valid high 6 consecutive cycles with instr_pc 0..5; Ack=1 the cycle after Halt; ret_count=6, cyc_count=7.
- Taken branch at pc 3 to target 10 -> pc 4 never valid (squashed); next valid instr_pc=10 two cycles after branch; ret_count excludes pc 4.
- BranchTaken and Halt asserted together at pc 2 -> DONE entered, target not fetched, ret_count=3.
- BranchTaken/Halt asserted while instr_valid=0 (bubble after a branch) -> ignored; flow continues at target.
- PCW=4, no branches, Halt placed at pc 1 after wrap (program runs 0..15,0,1) -> fetch_pc wraps 15->0 silently; ret_count=18; Req in DONE restarts from address 0 with counters cleared.
